// File: rtl/alu_error_monitor.sv
// Output stage for the duplicated self-checking ALU: classifies each X/Y sample,
// forwards one trusted result over valid/ready, and tracks errors with an OK/SUSPECT/FAULT FSM.
module alu_error_monitor #(
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned FAULT_LIMIT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       x,
   input  logic             xc,
   input  logic             xe0,
   input  logic             xe1,
   input  logic [2:0]       y,
   input  logic             yc,
   input  logic             ye0,
   input  logic             ye1,
   input  logic             clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       out_data,
   output logic             out_carry,
   output logic             out_err,
   output logic             out_src,
   output logic [1:0]       err_kind,
   output logic [1:0]       state,
   output logic             fault,
   output logic [CNT_W-1:0] err_count
);

   localparam int unsigned CONSEC_W = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_OK      = 2'b00,
      ST_SUSPECT = 2'b01,
      ST_FAULT   = 2'b10
   } state_t;

   state_t              r_state;
   logic                r_fault;
   logic [CONSEC_W-1:0] r_consec;
   logic [CNT_W-1:0]    r_err_count;

   logic                r_out_valid;
   logic [2:0]          r_out_data;
   logic                r_out_carry;
   logic                r_out_err;
   logic                r_out_src;
   logic [1:0]          r_err_kind;

   logic                w_rx_ok;
   logic                w_ry_ok;
   logic                w_match;
   logic                w_in_ready;
   logic                w_accept;
   logic [2:0]          w_data;
   logic                w_carry;
   logic                w_src;
   logic                w_err;
   logic [1:0]          w_kind;
   logic                w_is_err;
   logic [CONSEC_W:0]   w_consec_nxt;
   logic                w_hit_limit;
   logic                w_cnt_sat;

   assign w_rx_ok    = xe0 ^ xe1;
   assign w_ry_ok    = ye0 ^ ye1;
   assign w_match    = ({x, xc} == {y, yc});
   assign w_in_ready = !r_fault && !clr && (!r_out_valid || out_ready);
   assign w_accept   = in_valid && w_in_ready;

   // Consecutive count is widened by one bit so the limit compare cannot wrap.
   assign w_consec_nxt = {1'b0, r_consec} + (CONSEC_W + 1)'(1);
   assign w_hit_limit  = (w_consec_nxt >= (CONSEC_W + 1)'(FAULT_LIMIT));
   assign w_cnt_sat    = (r_err_count == CNT_MAX);

   // Pick the trusted copy and classify the sample from the two-rail checks.
   always_comb begin
      w_data   = x;
      w_carry  = xc;
      w_src    = 1'b0;
      w_err    = 1'b0;
      w_kind   = 2'b00;
      w_is_err = 1'b0;
      case ({w_rx_ok, w_ry_ok})
         2'b11: begin
            if (!w_match) begin
               w_err    = 1'b1;
               w_kind   = 2'b10;
               w_is_err = 1'b1;
            end
         end
         2'b10: begin
            w_kind   = 2'b01;
            w_is_err = 1'b1;
         end
         2'b01: begin
            w_data   = y;
            w_carry  = yc;
            w_src    = 1'b1;
            w_kind   = 2'b01;
            w_is_err = 1'b1;
         end
         default: begin
            w_err    = 1'b1;
            w_kind   = 2'b11;
            w_is_err = 1'b1;
         end
      endcase
   end

   // Result register: reloads on accept, otherwise drops valid once drained.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= 3'b000;
         r_out_carry <= 1'b0;
         r_out_err   <= 1'b0;
         r_out_src   <= 1'b0;
         r_err_kind  <= 2'b00;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_data;
         r_out_carry <= w_carry;
         r_out_err   <= w_err;
         r_out_src   <= w_src;
         r_err_kind  <= w_kind;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // Health FSM with error counters; only accepts or clr move it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_OK;
         r_fault     <= 1'b0;
         r_consec    <= '0;
         r_err_count <= '0;
      end else if (clr) begin
         r_state     <= ST_OK;
         r_fault     <= 1'b0;
         r_consec    <= '0;
         r_err_count <= '0;
      end else if (w_accept) begin
         if (w_is_err) begin
            r_consec <= w_consec_nxt[CONSEC_W-1:0];
            if (!w_cnt_sat) begin
               r_err_count <= r_err_count + CNT_W'(1);
            end
         end else begin
            r_consec <= '0;
         end
         case (r_state)
            ST_OK, ST_SUSPECT: begin
               if (w_is_err && w_hit_limit) begin
                  r_state <= ST_FAULT;
                  r_fault <= 1'b1;
               end else if (w_is_err) begin
                  r_state <= ST_SUSPECT;
               end else begin
                  r_state <= ST_OK;
               end
            end
            default: begin
               r_state <= ST_FAULT;
               r_fault <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_carry = r_out_carry;
   assign out_err   = r_out_err;
   assign out_src   = r_out_src;
   assign err_kind  = r_err_kind;
   assign state     = r_state;
   assign fault     = r_fault;
   assign err_count = r_err_count;

endmodule

// File: tb/tb_alu_error_monitor.sv
// Directed bench for alu_error_monitor: a vector table on the default build plus
// hand sequences for counter saturation and asynchronous reset on a small-counter build.
module tb_alu_error_monitor;

   typedef struct {
      logic       iv;
      logic       ordy;
      logic       clr;
      logic [2:0] x;
      logic       xc;
      logic [1:0] xe;
      logic [2:0] y;
      logic       yc;
      logic [1:0] ye;
      logic       rdy;
      logic       ov;
      logic [2:0] dat;
      logic       c;
      logic       err;
      logic       src;
      logic [1:0] kind;
      logic [1:0] st;
      logic       flt;
      logic [7:0] cnt;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, rst2;
   logic       in_valid, in_valid2, clr, clr2, out_ready, out_ready2;
   logic [2:0] x, y;
   logic       xc, yc, xe0, xe1, ye0, ye1;

   logic       in_ready, out_valid, out_carry, out_err, out_src, fault;
   logic [2:0] out_data;
   logic [1:0] err_kind, state;
   logic [7:0] err_count;

   logic       in_ready2, out_valid2, out_carry2, out_err2, out_src2, fault2;
   logic [2:0] out_data2;
   logic [1:0] err_kind2, state2;
   logic [1:0] err_count2;

   int n_checks = 0;
   int n_fail   = 0;
   vec_t vq[$];

   alu_error_monitor #(.CNT_W(8), .FAULT_LIMIT(3)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .xc(xc), .xe0(xe0), .xe1(xe1), .y(y), .yc(yc), .ye0(ye0), .ye1(ye1),
      .clr(clr), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_carry(out_carry), .out_err(out_err), .out_src(out_src), .err_kind(err_kind),
      .state(state), .fault(fault), .err_count(err_count)
   );

   alu_error_monitor #(.CNT_W(2), .FAULT_LIMIT(15)) u_dut2 (
      .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2),
      .x(x), .xc(xc), .xe0(xe0), .xe1(xe1), .y(y), .yc(yc), .ye0(ye0), .ye1(ye1),
      .clr(clr2), .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
      .out_carry(out_carry2), .out_err(out_err2), .out_src(out_src2), .err_kind(err_kind2),
      .state(state2), .fault(fault2), .err_count(err_count2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic void add(
      input logic iv, input logic ordy, input logic cl,
      input logic [2:0] vx, input logic vxc, input logic [1:0] vxe,
      input logic [2:0] vy, input logic vyc, input logic [1:0] vye,
      input logic rdy, input logic ov, input logic [2:0] dat, input logic c,
      input logic err, input logic src, input logic [1:0] kind,
      input logic [1:0] st, input logic flt, input logic [7:0] cnt);
      vec_t v;
      v.iv = iv; v.ordy = ordy; v.clr = cl;
      v.x = vx; v.xc = vxc; v.xe = vxe; v.y = vy; v.yc = vyc; v.ye = vye;
      v.rdy = rdy; v.ov = ov; v.dat = dat; v.c = c; v.err = err; v.src = src;
      v.kind = kind; v.st = st; v.flt = flt; v.cnt = cnt;
      vq.push_back(v);
   endfunction

   // Drive at the falling edge, check in_ready before the rising edge, outputs after it.
   task automatic run_vec(input vec_t v, input int idx);
      in_valid = v.iv; out_ready = v.ordy; clr = v.clr;
      x = v.x; xc = v.xc; {xe0, xe1} = v.xe;
      y = v.y; yc = v.yc; {ye0, ye1} = v.ye;
      #1;
      chk($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'(v.rdy));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'(v.ov));
      chk($sformatf("v%0d out_data", idx),  32'(out_data),  32'(v.dat));
      chk($sformatf("v%0d out_carry", idx), 32'(out_carry), 32'(v.c));
      chk($sformatf("v%0d out_err", idx),   32'(out_err),   32'(v.err));
      chk($sformatf("v%0d out_src", idx),   32'(out_src),   32'(v.src));
      chk($sformatf("v%0d err_kind", idx),  32'(err_kind),  32'(v.kind));
      chk($sformatf("v%0d state", idx),     32'(state),     32'(v.st));
      chk($sformatf("v%0d fault", idx),     32'(fault),     32'(v.flt));
      chk($sformatf("v%0d err_count", idx), 32'(err_count), 32'(v.cnt));
   endtask

   initial begin
      rst = 1'b1; rst2 = 1'b1;
      in_valid = 1'b0; in_valid2 = 1'b0; clr = 1'b0; clr2 = 1'b0;
      out_ready = 1'b0; out_ready2 = 1'b0;
      x = 3'b000; y = 3'b000; xc = 1'b0; yc = 1'b0;
      xe0 = 1'b0; xe1 = 1'b0; ye0 = 1'b0; ye1 = 1'b0;

      //   iv ordy clr  x    xc xe     y    yc ye   | rdy ov dat  c err src kind  st  flt cnt
      add(1, 1, 0, 3'b101, 0, 2'b01, 3'b101, 0, 2'b10, 1, 1, 3'b101, 0, 0, 0, 2'b00, 2'b00, 0, 8'd0);
      add(1, 1, 0, 3'b010, 0, 2'b11, 3'b110, 0, 2'b01, 1, 1, 3'b110, 0, 0, 1, 2'b01, 2'b01, 0, 8'd1);
      add(1, 1, 0, 3'b001, 1, 2'b01, 3'b001, 1, 2'b01, 1, 1, 3'b001, 1, 0, 0, 2'b00, 2'b00, 0, 8'd1);
      add(1, 1, 0, 3'b011, 0, 2'b01, 3'b111, 0, 2'b10, 1, 1, 3'b011, 0, 1, 0, 2'b10, 2'b01, 0, 8'd2);
      add(1, 1, 0, 3'b100, 1, 2'b00, 3'b010, 0, 2'b11, 1, 1, 3'b100, 1, 1, 0, 2'b11, 2'b01, 0, 8'd3);
      add(1, 1, 0, 3'b110, 0, 2'b10, 3'b110, 0, 2'b01, 1, 1, 3'b110, 0, 0, 0, 2'b00, 2'b00, 0, 8'd3);
      add(1, 1, 0, 3'b111, 1, 2'b10, 3'b000, 0, 2'b00, 1, 1, 3'b111, 1, 0, 0, 2'b01, 2'b01, 0, 8'd4);
      add(0, 1, 0, 3'b000, 0, 2'b00, 3'b000, 0, 2'b00, 1, 0, 3'b111, 1, 0, 0, 2'b01, 2'b01, 0, 8'd4);
      add(1, 1, 0, 3'b010, 0, 2'b01, 3'b010, 0, 2'b01, 1, 1, 3'b010, 0, 0, 0, 2'b00, 2'b00, 0, 8'd4);
      // Backpressure: output must hold for five cycles, then drain and accept together.
      for (int i = 0; i < 5; i++)
         add(1, 0, 0, 3'b001, 0, 2'b01, 3'b001, 0, 2'b01, 0, 1, 3'b010, 0, 0, 0, 2'b00, 2'b00, 0, 8'd4);
      add(1, 1, 0, 3'b001, 0, 2'b01, 3'b001, 0, 2'b01, 1, 1, 3'b001, 0, 0, 0, 2'b00, 2'b00, 0, 8'd4);
      // Three consecutive mismatches reach FAULT; the third result is still delivered.
      add(1, 1, 0, 3'b000, 0, 2'b01, 3'b001, 0, 2'b01, 1, 1, 3'b000, 0, 1, 0, 2'b10, 2'b01, 0, 8'd5);
      add(1, 1, 0, 3'b000, 0, 2'b01, 3'b001, 0, 2'b01, 1, 1, 3'b000, 0, 1, 0, 2'b10, 2'b01, 0, 8'd6);
      add(1, 1, 0, 3'b000, 0, 2'b01, 3'b001, 0, 2'b01, 1, 1, 3'b000, 0, 1, 0, 2'b10, 2'b10, 1, 8'd7);
      add(1, 1, 0, 3'b101, 0, 2'b01, 3'b101, 0, 2'b01, 0, 0, 3'b000, 0, 1, 0, 2'b10, 2'b10, 1, 8'd7);
      add(0, 1, 1, 3'b000, 0, 2'b00, 3'b000, 0, 2'b00, 0, 0, 3'b000, 0, 1, 0, 2'b10, 2'b00, 0, 8'd0);
      add(1, 1, 0, 3'b101, 0, 2'b01, 3'b101, 0, 2'b01, 1, 1, 3'b101, 0, 0, 0, 2'b00, 2'b00, 0, 8'd0);
      // clr with a held result leaves the result untouched.
      add(0, 0, 1, 3'b000, 0, 2'b00, 3'b000, 0, 2'b00, 0, 1, 3'b101, 0, 0, 0, 2'b00, 2'b00, 0, 8'd0);
      add(0, 1, 0, 3'b000, 0, 2'b00, 3'b000, 0, 2'b00, 1, 0, 3'b101, 0, 0, 0, 2'b00, 2'b00, 0, 8'd0);

      repeat (2) @(negedge clk);
      rst = 1'b0; rst2 = 1'b0;
      #1;
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst out_data",  32'(out_data),  32'd0);
      chk("rst out_carry", 32'(out_carry), 32'd0);
      chk("rst out_err",   32'(out_err),   32'd0);
      chk("rst out_src",   32'(out_src),   32'd0);
      chk("rst err_kind",  32'(err_kind),  32'd0);
      chk("rst state",     32'(state),     32'd0);
      chk("rst fault",     32'(fault),     32'd0);
      chk("rst err_count", 32'(err_count), 32'd0);
      chk("rst in_ready",  32'(in_ready),  32'd1);
      @(negedge clk);

      for (int i = 0; i < vq.size(); i++) run_vec(vq[i], i);
      in_valid = 1'b0; clr = 1'b0;

      // Small counter build: five mismatches saturate err_count at 3 without faulting.
      x = 3'b000; xc = 1'b0; {xe0, xe1} = 2'b01;
      y = 3'b001; yc = 1'b0; {ye0, ye1} = 2'b01;
      in_valid2 = 1'b1; out_ready2 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("sat%0d in_ready", i), 32'(in_ready2), 32'd1);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("sat%0d err_count", i), 32'(err_count2), (i < 3) ? 32'(i + 1) : 32'd3);
         chk($sformatf("sat%0d state", i), 32'(state2), 32'd1);
         chk($sformatf("sat%0d fault", i), 32'(fault2), 32'd0);
      end
      in_valid2 = 1'b0; out_ready2 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("hold out_valid", 32'(out_valid2), 32'd1);
      chk("hold out_err", 32'(out_err2), 32'd1);
      #2;
      rst2 = 1'b1;
      #1;
      chk("async rst out_valid", 32'(out_valid2), 32'd0);
      chk("async rst err_count", 32'(err_count2), 32'd0);
      chk("async rst state", 32'(state2), 32'd0);
      @(negedge clk);
      rst2 = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_error_monitor.md
# alu_error_monitor

Registered output stage placed directly downstream of the duplicated, self-checking ALU `main`. It consumes both ALU copies' results (X, Y with carries), together with their two-rail error indicators (XE0/XE1, YE0/YE1). Each accepted sample is classified as clean, one-rail-bad, mismatch or both-rail-bad, and a single trusted result is forwarded over a valid/ready handshake. The block also keeps a saturating error count and runs an OK/SUSPECT/FAULT state machine that halts intake after repeated consecutive errors.

## Interface
- CNT_W, 8, width of the saturating error counter.
- FAULT_LIMIT, 3, number of consecutive erroneous samples that forces FAULT; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample present on x*/y* inputs.
- in_ready  out  1  block can accept a sample this cycle.
- x  in  3  ALU copy X result {X2,X1,X0}.
- xc  in  1  ALU copy X carry.
- xe0, xe1  in  1 each  two-rail code for copy X; valid when exactly one is 1.
- y  in  3  ALU copy Y result {Y2,Y1,Y0}.
- yc  in  1  ALU copy Y carry.
- ye0, ye1  in  1 each  two-rail code for copy Y.
- clr  in  1  single-cycle pulse; clears FAULT, the consecutive-error count and err_count.
- out_valid  out  1  registered result available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  3  forwarded result.
- out_carry  out  1  forwarded carry.
- out_err  out  1  forwarded result is untrusted.
- out_src  out  1  0 = taken from X, 1 = taken from Y.
- err_kind  out  2  00 clean, 01 one rail bad, 10 X/Y mismatch, 11 both rails bad.
- state  out  2  00 OK, 01 SUSPECT, 10 FAULT.
- fault  out  1  high while state is FAULT.
- err_count  out  CNT_W  total erroneous samples accepted, saturating.

## Operation
- Definitions:
  - rx_ok = xe0 ^ xe1; ry_ok = ye0 ^ ye1.
  - A sample is accepted when in_valid && in_ready.
- Classification of an accepted sample:
  - rx_ok && ry_ok && {x,xc}=={y,yc}: clean. Forward X, out_err=0, err_kind=00.
  - rx_ok && ry_ok && mismatch: error. Forward X, out_err=1, err_kind=10.
  - Exactly one of rx_ok/ry_ok: error. Forward the ok copy (out_src = 1 if only Y is ok), out_err=0, err_kind=01.
  - Neither ok: error. Forward X, out_err=1, err_kind=11.
- Counting:
  - Every erroneous accept increments err_count; it saturates at 2^CNT_W-1 and never wraps.
  - A 4-bit consecutive-error counter (consec) increments on each error accept and resets to 0 on each clean accept.
- State machine, updated only on accepts or clr:
  - OK -> SUSPECT on an error accept when consec+1 < FAULT_LIMIT.
  - OK or SUSPECT -> FAULT on an error accept when consec+1 == FAULT_LIMIT. With FAULT_LIMIT=1, the first error goes straight to FAULT.
  - SUSPECT -> OK on a clean accept.
  - FAULT is sticky. Only clr (-> OK, consec=0, err_count=0) or rst leaves it.
- in_ready = !fault && !clr && (!out_valid || out_ready). Consequences:
  - No sample is accepted in the clr cycle.
  - No sample is accepted while in FAULT.
- The sample that triggers FAULT is still registered and presented. A result already held drains normally while in FAULT.

## Timing
- Reset values: out_valid=0, out_data=0, out_carry=0, out_err=0, out_src=0, err_kind=00, state=OK, fault=0, err_count=0, consec=0.
- rst asserted mid-operation discards any held result immediately.
- Latency is 1 cycle: a sample accepted at edge N gives out_valid=1 and its fields after edge N. State, fault and err_count also update at edge N.
- Output register rules:
  - It holds its value while out_valid && !out_ready.
  - It reloads on a simultaneous drain and accept, giving full throughput of 1 sample/cycle.
  - out_valid falls after a drain with no new accept.
- in_ready is combinational from out_valid, out_ready, fault and clr. There is no combinational path from x/y data to any output.
- clr takes effect at the next edge. If out_valid is high in the clr cycle, the held result is unaffected.

## Test plan
- Reset, then send x=3'b101, xc=0, y=3'b101, yc=0, xe=01, ye=10 with out_ready=1 -> next cycle out_valid=1, out_data=101, out_err=0, err_kind=00, state=OK, err_count=0.
- Send X rail xe=11, ye=01, x=010, y=110 -> out_data=110, out_src=1, out_err=0, err_kind=01, state=SUSPECT, err_count=1. Then send one clean sample -> state=OK, err_count stays 1.
- Both rails ok with x=011, y=111 -> out_data=011, out_err=1, err_kind=10. Then send xe=00, ye=11 -> out_err=1, err_kind=11.
- Backpressure: hold out_ready=0 with out_valid=1 -> in_ready=0 and the output stays stable for 5 cycles. Release with in_valid=1 -> drain and accept occur in the same cycle, with no bubble.
- FAULT_LIMIT=3: send three consecutive error samples -> state goes 01,01,10, fault=1, in_ready=0, and the third result is still delivered. Pulse clr -> state=OK, err_count=0, in_ready=1 the following cycle.
- CNT_W=2: send 5 error samples with FAULT_LIMIT=15 -> err_count stays at 3. Assert rst during a held output -> out_valid=0 immediately.
